// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply engine: FSM encoding and
// the positions of the row/column fields inside a matrix header word.
package matmul_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned ADDR_W_DEFAULT = 12;

   // A header word is viewed as two half-words: [1] = rows, [0] = cols.
   localparam bit HDR_ROWS = 1'b1;
   localparam bit HDR_COLS = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_CHK,
      S_RUN,
      S_DRAIN
   } state_t;

endpackage

// File: rtl/matmul_if.sv
// Start/config handshake plus the A/B read ports and C write port of the engine.
// slave = engine side, master = controller/memory side.
interface matmul_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 12
);
   logic              dut_valid;
   logic              dut_ready;
   logic              cfg_transpose_b;
   logic [ADDR_W-1:0] cfg_a_base;
   logic [ADDR_W-1:0] cfg_b_base;
   logic [ADDR_W-1:0] cfg_c_base;
   logic              err;
   logic [ADDR_W-1:0] a_read_address;
   logic [DATA_W-1:0] a_read_data;
   logic [ADDR_W-1:0] b_read_address;
   logic [DATA_W-1:0] b_read_data;
   logic              c_write_enable;
   logic [ADDR_W-1:0] c_write_address;
   logic [DATA_W-1:0] c_write_data;

   modport slave (
      input  dut_valid, cfg_transpose_b, cfg_a_base, cfg_b_base, cfg_c_base,
             a_read_data, b_read_data,
      output dut_ready, err, a_read_address, b_read_address,
             c_write_enable, c_write_address, c_write_data
   );

   modport master (
      output dut_valid, cfg_transpose_b, cfg_a_base, cfg_b_base, cfg_c_base,
             a_read_data, b_read_data,
      input  dut_ready, err, a_read_address, b_read_address,
             c_write_enable, c_write_address, c_write_data
   );
endinterface

// File: rtl/int_mac.sv
// Registered signed multiply-accumulate; clear restarts the sum at the current product.
// sum_c exposes the value the accumulator is about to take.
module int_mac #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clear,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum_c
);

   logic        [W-1:0] acc;
   logic signed [W-1:0] prod;

   // Low W bits of the signed product: wrap-around, no saturation.
   assign prod  = $signed(a) * $signed(b);
   assign sum_c = clear ? W'(prod) : acc + W'(prod);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum_c;
      end
   end

endmodule

// File: rtl/matmul_engine.sv
// SRAM-to-SRAM integer matrix multiply C = A * B (or A * B^T), one MAC per cycle.
// Headers are checked first; C is written element by element in row-major order.
module matmul_engine
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input logic     clk,
   input logic     reset,
   matmul_if.slave bus
);

   localparam int unsigned DIM_W = DATA_W / 2;

   typedef logic [DIM_W-1:0]  dim_t;
   typedef logic [ADDR_W-1:0] addr_t;

   state_t            state;
   logic              ready;
   logic              err_flag;
   logic              c_we;
   addr_t             c_waddr;
   logic [DATA_W-1:0] c_wdata;
   addr_t             a_addr;
   addr_t             b_addr;

   logic  transpose;
   addr_t a_base, b_base, c_base;
   dim_t  m_dim, k_dim, n_dim;
   dim_t  i_cnt, j_cnt, k_cnt;
   addr_t a_row, b_col, c_addr;

   // Tags travelling with each read pair into the data cycle.
   logic  d_valid, d_first, d_last;
   addr_t d_caddr;

   logic [1:0][DIM_W-1:0] a_hdr, b_hdr;
   dim_t                  b_inner, b_outer;
   logic                  k_end, j_end, i_end;
   logic [DATA_W-1:0]     mac_sum;

   assign a_hdr   = bus.a_read_data;
   assign b_hdr   = bus.b_read_data;
   assign b_inner = transpose ? b_hdr[HDR_COLS] : b_hdr[HDR_ROWS];
   assign b_outer = transpose ? b_hdr[HDR_ROWS] : b_hdr[HDR_COLS];

   assign k_end = (k_cnt == k_dim - dim_t'(1));
   assign j_end = (j_cnt == n_dim - dim_t'(1));
   assign i_end = (i_cnt == m_dim - dim_t'(1));

   assign bus.dut_ready       = ready;
   assign bus.err             = err_flag;
   assign bus.a_read_address  = a_addr;
   assign bus.b_read_address  = b_addr;
   assign bus.c_write_enable  = c_we;
   assign bus.c_write_address = c_waddr;
   assign bus.c_write_data    = c_wdata;

   int_mac #(.W(DATA_W)) u_mac (
      .clk   (clk),
      .reset (reset),
      .en    (d_valid),
      .clear (d_first),
      .a     (bus.a_read_data),
      .b     (bus.b_read_data),
      .sum_c (mac_sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ready     <= 1'b1;
         err_flag  <= 1'b0;
         c_we      <= 1'b0;
         c_waddr   <= '0;
         c_wdata   <= '0;
         a_addr    <= '0;
         b_addr    <= '0;
         transpose <= 1'b0;
         a_base    <= '0;
         b_base    <= '0;
         c_base    <= '0;
         m_dim     <= '0;
         k_dim     <= '0;
         n_dim     <= '0;
         i_cnt     <= '0;
         j_cnt     <= '0;
         k_cnt     <= '0;
         a_row     <= '0;
         b_col     <= '0;
         c_addr    <= '0;
         d_valid   <= 1'b0;
         d_first   <= 1'b0;
         d_last    <= 1'b0;
         d_caddr   <= '0;
      end else begin
         c_we    <= 1'b0;
         d_valid <= 1'b0;

         // Final partial sum of an element lands two cycles after its last read.
         if (d_valid && d_last) begin
            c_we    <= 1'b1;
            c_waddr <= d_caddr;
            c_wdata <= mac_sum;
         end

         unique case (state)
            S_IDLE: begin
               if (bus.dut_valid && ready) begin
                  state     <= S_HDR;
                  ready     <= 1'b0;
                  err_flag  <= 1'b0;
                  transpose <= bus.cfg_transpose_b;
                  a_base    <= bus.cfg_a_base;
                  b_base    <= bus.cfg_b_base;
                  c_base    <= bus.cfg_c_base;
                  a_addr    <= bus.cfg_a_base;
                  b_addr    <= bus.cfg_b_base;
               end
            end

            S_HDR: begin
               state <= S_CHK;
            end

            S_CHK: begin
               if (a_hdr[HDR_COLS] != b_inner) begin
                  err_flag <= 1'b1;
                  ready    <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  c_we    <= 1'b1;
                  c_waddr <= c_base;
                  c_wdata <= {a_hdr[HDR_ROWS], b_outer};
                  m_dim   <= a_hdr[HDR_ROWS];
                  k_dim   <= a_hdr[HDR_COLS];
                  n_dim   <= b_outer;
                  if (a_hdr[HDR_ROWS] == '0 || a_hdr[HDR_COLS] == '0 || b_outer == '0) begin
                     ready <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     state  <= S_RUN;
                     i_cnt  <= '0;
                     j_cnt  <= '0;
                     k_cnt  <= '0;
                     a_addr <= a_base + addr_t'(1);
                     a_row  <= a_base + addr_t'(1);
                     b_addr <= b_base + addr_t'(1);
                     b_col  <= b_base + addr_t'(1);
                     c_addr <= c_base + addr_t'(1);
                  end
               end
            end

            S_RUN: begin
               d_valid <= 1'b1;
               d_first <= (k_cnt == '0);
               d_last  <= k_end;
               d_caddr <= c_addr;
               if (!k_end) begin
                  k_cnt  <= k_cnt + dim_t'(1);
                  a_addr <= a_addr + addr_t'(1);
                  b_addr <= transpose ? b_addr + addr_t'(1) : b_addr + addr_t'(n_dim);
               end else begin
                  k_cnt  <= '0;
                  c_addr <= c_addr + addr_t'(1);
                  if (!j_end) begin
                     // Next column of the same A row: rewind A, step to next B column.
                     j_cnt  <= j_cnt + dim_t'(1);
                     a_addr <= a_row;
                     b_addr <= transpose ? b_addr + addr_t'(1) : b_col + addr_t'(1);
                     b_col  <= b_col + addr_t'(1);
                  end else begin
                     j_cnt  <= '0;
                     a_addr <= a_addr + addr_t'(1);
                     a_row  <= a_addr + addr_t'(1);
                     b_addr <= b_base + addr_t'(1);
                     b_col  <= b_base + addr_t'(1);
                     if (i_end) begin
                        state <= S_DRAIN;
                     end else begin
                        i_cnt <= i_cnt + dim_t'(1);
                     end
                  end
               end
            end

            S_DRAIN: begin
               if (!d_valid) begin
                  ready <= 1'b1;
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: a reference matrix product fills an expected
// write queue, a negedge monitor pops and compares every C write.
module tb_matmul_engine;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   cyc;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] a_mem [4096];
   logic [31:0] b_mem [4096];
   logic [31:0] amat  [8][8];
   logic [31:0] bmat  [8][8];

   matmul_if #(.DATA_W(32), .ADDR_W(12)) bus ();

   matmul_engine #(.DATA_W(32), .ADDR_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read SRAM models: data one cycle after the address.
   always @(posedge clk) begin
      bus.a_read_data <= a_mem[bus.a_read_address];
      bus.b_read_data <= b_mem[bus.b_read_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every C write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && bus.c_write_enable === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL c_write_unexpected actual=%0h@%0h expected=none",
                     bus.c_write_data, bus.c_write_address);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.c_write_address !== mon_e.addr || bus.c_write_data !== mon_e.data) begin
               bad++;
               $display("FAIL c_write actual=%0h@%0h expected=%0h@%0h",
                        bus.c_write_data, bus.c_write_address, mon_e.data, mon_e.addr);
            end
         end
      end
   end

   task automatic run_job(input int m, input int k, input int n, input int kb, input bit tr,
                          input logic [11:0] ab, input logic [11:0] bb, input logic [11:0] cb,
                          input bit rand_data, input bit poke, input int abort_at);
      logic [31:0] acc;
      int          lat_exp, t, t0, e;
      bit          mism, zero, seen;
      mism = (kb != k);
      zero = !mism && (m == 0 || k == 0 || n == 0);
      if (rand_data) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
               amat[i][j] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 40)) - 32'd20;
               bmat[i][j] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 40)) - 32'd20;
            end
      end
      a_mem[ab] = {16'(m), 16'(k)};
      b_mem[bb] = tr ? {16'(n), 16'(kb)} : {16'(kb), 16'(n)};
      for (int i = 0; i < m; i++)
         for (int kk = 0; kk < k; kk++)
            a_mem[12'(32'(ab) + 1 + i * k + kk)] = amat[i][kk];
      for (int kk = 0; kk < k; kk++)
         for (int j = 0; j < n; j++)
            if (tr) b_mem[12'(32'(bb) + 1 + j * k + kk)] = bmat[kk][j];
            else    b_mem[12'(32'(bb) + 1 + kk * n + j)] = bmat[kk][j];

      // Reference: header then row-major dot products, truncated to 32 bits.
      if (!mism && (abort_at == 0 || abort_at >= 3))
         exp_q.push_back('{addr: cb, data: {16'(m), 16'(n)}});
      if (!mism && !zero) begin
         for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
               acc = 32'd0;
               for (int kk = 0; kk < k; kk++) acc = acc + amat[i][kk] * bmat[kk][j];
               e = i * n + j;
               if (abort_at == 0 || (e + 1) * k + 4 <= abort_at)
                  exp_q.push_back('{addr: 12'(32'(cb) + 1 + e), data: acc});
            end
      end
      lat_exp = (mism || zero) ? 3 : m * n * k + 5;

      @(negedge clk);
      check("ready_before_start", 32'(bus.dut_ready), 32'd1);
      bus.cfg_transpose_b = tr;
      bus.cfg_a_base      = ab;
      bus.cfg_b_base      = bb;
      bus.cfg_c_base      = cb;
      bus.dut_valid       = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1 bus.dut_valid = poke;
      seen = 1'b0;
      for (int w = 0; w < 3000; w++) begin
         @(negedge clk);
         t = cyc - t0;
         if (t == 1) begin
            check("ready_low_after_accept", 32'(bus.dut_ready), 32'd0);
            check("err_cleared_on_start", 32'(bus.err), 32'd0);
         end
         if (abort_at != 0 && t == abort_at) begin
            bus.dut_valid = 1'b0;
            #1 reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("abort_ready", 32'(bus.dut_ready), 32'd1);
            check("abort_c_we", 32'(bus.c_write_enable), 32'd0);
            check("abort_a_addr", 32'(bus.a_read_address), 32'd0);
            check("abort_c_addr", 32'(bus.c_write_address), 32'd0);
            seen = 1'b1;
            break;
         end
         if (bus.dut_ready) begin
            bus.dut_valid = 1'b0;
            check("ready_latency", 32'(t), 32'(lat_exp));
            check("err_flag", 32'(bus.err), 32'(mism));
            seen = 1'b1;
            break;
         end
         if (poke) begin
            bus.cfg_transpose_b = 1'($urandom_range(0, 1));
            bus.cfg_a_base      = 12'($urandom());
            bus.cfg_b_base      = 12'($urandom());
            bus.cfg_c_base      = 12'($urandom());
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL ready_timeout actual=busy expected=ready within 3000 cycles");
         bus.dut_valid = 1'b0;
      end
      repeat (4) @(negedge clk);
      check("err_hold", 32'(bus.err), (abort_at != 0) ? 32'd0 : 32'(mism));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic load_small;
      for (int i = 0; i < 2; i++)
         for (int kk = 0; kk < 3; kk++) amat[i][kk] = 32'(i * 3 + kk + 1);
      for (int kk = 0; kk < 3; kk++)
         for (int j = 0; j < 2; j++) bmat[kk][j] = 32'(7 + kk * 2 + j);
   endtask

   initial begin
      int rm, rk, rn;
      total = 0;
      bad   = 0;
      cyc   = 0;
      reset = 1'b1;
      bus.dut_valid       = 1'b0;
      bus.cfg_transpose_b = 1'b0;
      bus.cfg_a_base      = '0;
      bus.cfg_b_base      = '0;
      bus.cfg_c_base      = '0;
      for (int i = 0; i < 4096; i++) begin
         a_mem[i] = '0;
         b_mem[i] = '0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_ready", 32'(bus.dut_ready), 32'd1);
      check("reset_err", 32'(bus.err), 32'd0);
      check("reset_c_we", 32'(bus.c_write_enable), 32'd0);
      check("reset_a_addr", 32'(bus.a_read_address), 32'd0);
      check("reset_b_addr", 32'(bus.b_read_address), 32'd0);
      check("reset_c_addr", 32'(bus.c_write_address), 32'd0);
      check("reset_c_data", bus.c_write_data, 32'd0);

      load_small();
      run_job(2, 3, 2, 3, 1'b0, 12'h010, 12'h020, 12'h100, 1'b0, 1'b0, 0);
      run_job(2, 3, 2, 3, 1'b1, 12'h030, 12'h040, 12'h110, 1'b0, 1'b1, 0);
      run_job(2, 3, 2, 2, 1'b0, 12'h050, 12'h060, 12'h120, 1'b0, 1'b0, 0);
      run_job(0, 3, 2, 3, 1'b0, 12'h070, 12'h080, 12'h130, 1'b0, 1'b0, 0);
      run_job(2, 3, 0, 3, 1'b1, 12'h070, 12'h080, 12'h138, 1'b0, 1'b0, 0);

      amat[0][0] = 32'h7FFF_FFFF;
      bmat[0][0] = 32'd2;
      run_job(1, 1, 1, 1, 1'b0, 12'h090, 12'h0A0, 12'h140, 1'b0, 1'b0, 0);
      amat[0][0] = -32'sd3;
      bmat[0][0] = 32'd5;
      run_job(1, 1, 1, 1, 1'b1, 12'h090, 12'h0A0, 12'h150, 1'b0, 1'b1, 0);

      load_small();
      run_job(2, 3, 2, 3, 1'b0, 12'h010, 12'h020, 12'h200, 1'b0, 1'b0, 8);
      run_job(2, 3, 2, 3, 1'b0, 12'h010, 12'h020, 12'h200, 1'b0, 1'b0, 0);

      run_job(2, 2, 2, 2, 1'b0, 12'hFF8, 12'hFFD, 12'hFFE, 1'b1, 1'b0, 0);

      for (int r = 0; r < 12; r++) begin
         rm = $urandom_range(1, 4);
         rk = $urandom_range(1, 4);
         rn = $urandom_range(1, 4);
         run_job(rm, rk, rn, rk, 1'($urandom_range(0, 1)), 12'($urandom()), 12'($urandom()),
                 12'($urandom()), 1'b1, 1'($urandom_range(0, 1)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
